// File: rtl/mem_xfer_pkg.sv
// Shared types for the cache-line transfer engine on the word-wide memory port.
package mem_xfer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } xfer_state_e;

    // Beat counter width; floors at 1 so a degenerate line size still compiles.
    function automatic int beat_w(input int line_words);
        return (line_words <= 1) ? 1 : $clog2(line_words);
    endfunction

endpackage

// File: rtl/mem_line_xfer.sv
// Line fill / writeback initiator: turns one line request into LINE_WORDS
// single-word memory accesses and returns the assembled line or a completion.
module mem_line_xfer
    import mem_xfer_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic                         req_write_i,
    input  logic [ADDR_W-1:0]            req_addr_i,
    input  logic [LINE_WORDS*DATA_W-1:0] req_wdata_i,
    output logic                         resp_valid_o,
    input  logic                         resp_ready_i,
    output logic [LINE_WORDS*DATA_W-1:0] resp_rdata_o,
    output logic                         mem_wr_en_o,
    output logic [ADDR_W-1:0]            mem_addr_o,
    output logic [DATA_W-1:0]            mem_wdata_o,
    input  logic [DATA_W-1:0]            mem_rdata_i
);

    localparam int BEAT_W = beat_w(LINE_WORDS);
    localparam int LINE_W = LINE_WORDS * DATA_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    xfer_state_e         state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LINE_W-1:0]   wline_q, wline_d;
    logic [LINE_W-1:0]   rline_q, rline_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        wline_d = wline_q;
        rline_d = rline_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    // Line-align the address; beats then never carry past the line.
                    base_d  = {req_addr_i[ADDR_W-1:BEAT_W], {BEAT_W{1'b0}}};
                    wline_d = req_wdata_i;
                    beat_d  = '0;
                    state_d = req_write_i ? WRITE : READ;
                end
            end
            WRITE: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) state_d = RESP;
            end
            READ: begin
                rline_d[beat_q*DATA_W +: DATA_W] = mem_rdata_i;
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) state_d = RESP;
            end
            RESP: begin
                if (resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory-side outputs decode straight from state so reset drops them at once.
    always_comb begin
        mem_wr_en_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (state_q == WRITE) begin
            mem_wr_en_o = 1'b1;
            mem_addr_o  = base_q + ADDR_W'(beat_q);
            mem_wdata_o = wline_q[beat_q*DATA_W +: DATA_W];
        end else if (state_q == READ) begin
            mem_addr_o  = base_q + ADDR_W'(beat_q);
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == RESP);
    assign resp_rdata_o = rline_q;

endmodule

// File: tb/tb_mem_line_xfer.sv
// Directed bench for mem_line_xfer against a small word-addressed memory.
module tb_mem_line_xfer;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;
    localparam int LINE_W = LW * DW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [AW-1:0]     req_addr = '0;
    logic [LINE_W-1:0] req_wdata = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [LINE_W-1:0] resp_rdata;
    logic              mem_wr_en;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    logic              init_done = 1'b0;
    logic [DW-1:0]     mem [0:1023];

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    mem_line_xfer #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata),
        .mem_wr_en_o (mem_wr_en),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    // Preload every word with 0x5000_0000 | index, then behave as a plain RAM.
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h5000_0000 | i;
        end else if (mem_wr_en) begin
            mem[mem_addr[9:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[9:0]];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [LINE_W-1:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        step();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    // Called at cycle 1 after acceptance; returns write-beat count and resp cycle.
    task automatic wait_resp(output int wr_cnt, output int cyc);
        wr_cnt = 0;
        cyc = -1;
        for (int k = 1; k <= 12; k++) begin
            if (mem_wr_en) wr_cnt++;
            if (resp_valid) begin
                cyc = k;
                break;
            end
            step();
        end
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int wr_cnt;
        int cyc;
        logic seen;
        logic [LINE_W-1:0] line;
        logic [LINE_W-1:0] held;

        step();
        init_done = 1'b1;
        step();

        // 1: reset asserted mid-cycle, outputs must be at reset values at once
        #3 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_rdata", resp_rdata, '0);
        chk("rst_mem_wr_en", mem_wr_en, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        step();
        step();
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("post_rst_ready", req_ready, 1'b1);

        // 2: writeback to 0x13, low bits ignored so the line lands at 0x10..0x13
        line = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        issue(1'b1, 32'h13, line);
        chk("wb_beat0_wr_en", mem_wr_en, 1'b1);
        chk("wb_beat0_addr", mem_addr, 32'h10);
        chk("wb_beat0_wdata", mem_wdata, 32'hAAAA_0001);
        chk("wb_busy_not_ready", req_ready, 1'b0);
        wait_resp(wr_cnt, cyc);
        chk("wb_wr_cycles", wr_cnt, 4);
        chk("wb_resp_cycle", cyc, 5);
        chk("wb_resp_addr_zero", mem_addr, '0);
        handshake();
        chk("wb_idle_ready", req_ready, 1'b1);
        chk("wb_idle_resp_valid", resp_valid, 1'b0);
        chk("wb_rdata_untouched", resp_rdata, '0);
        chk("wb_mem_line", {mem[19], mem[18], mem[17], mem[16]}, line);

        // 3: fill the same line back
        issue(1'b0, 32'h10, '0);
        chk("fill_beat0_addr", mem_addr, 32'h10);
        wait_resp(wr_cnt, cyc);
        chk("fill_wr_cycles", wr_cnt, 0);
        chk("fill_resp_cycle", cyc, 5);
        chk("fill_rdata", resp_rdata, line);

        // 4: hold off the response for three cycles
        held = resp_rdata;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (!resp_valid || resp_rdata !== held || req_ready) seen = 1'b1;
        end
        chk("bp_stable", seen, 1'b0);
        handshake();
        chk("bp_release_ready", req_ready, 1'b1);
        chk("bp_release_valid", resp_valid, 1'b0);

        // 5: junk on request inputs during a fill; it is accepted only after the handshake
        issue(1'b0, 32'h22, '0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h41;
        req_wdata = {32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000};
        chk("b2b_read_addr", mem_addr, 32'h20);
        wait_resp(wr_cnt, cyc);
        chk("b2b_read_wr_cycles", wr_cnt, 0);
        chk("b2b_read_resp_cycle", cyc, 5);
        chk("b2b_read_rdata", resp_rdata,
            {32'h5000_0023, 32'h5000_0022, 32'h5000_0021, 32'h5000_0020});
        chk("b2b_resp_not_ready", req_ready, 1'b0);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("b2b_idle_ready", req_ready, 1'b1);
        chk("b2b_idle_no_write", mem_wr_en, 1'b0);
        step();
        req_valid = 1'b0;
        chk("b2b_second_wr_en", mem_wr_en, 1'b1);
        chk("b2b_second_addr", mem_addr, 32'h40);
        wait_resp(wr_cnt, cyc);
        chk("b2b_second_wr_cycles", wr_cnt, 4);
        chk("b2b_second_resp_cycle", cyc, 5);
        chk("b2b_rdata_held", resp_rdata,
            {32'h5000_0023, 32'h5000_0022, 32'h5000_0021, 32'h5000_0020});
        handshake();
        chk("b2b_second_mem", {mem[67], mem[66], mem[65], mem[64]},
            {32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000});
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        // 6: reset during beat 2 of a writeback
        issue(1'b1, 32'h30, {32'h6666_0003, 32'h6666_0002, 32'h6666_0001, 32'h6666_0000});
        step();
        step();
        chk("abort_beat2_addr", mem_addr, 32'h32);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_wr_en_drop", mem_wr_en, 1'b0);
        chk("abort_addr_zero", mem_addr, '0);
        chk("abort_resp_valid", resp_valid, 1'b0);
        chk("abort_rdata_cleared", resp_rdata, '0);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (resp_valid || !req_ready) seen = 1'b1;
        end
        chk("abort_no_resp", seen, 1'b0);
        chk("abort_word0", mem[48], 32'h6666_0000);
        chk("abort_word1", mem[49], 32'h6666_0001);
        chk("abort_word3", mem[51], 32'h5000_0033);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
